// File: rtl/pc_trace_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module      : pc_trace_buffer_if
//  Description : Drain-side valid/ready bus of the PC trace buffer.
//                The buffer (master) presents the head entry; the debug or
//                UART consumer (slave) accepts it with out_ready.
//  Signals     : out_valid  head entry valid
//                out_ready  consumer accepts head this cycle
//                out_pc     head program counter
//                out_ins    head instruction word
//  Revision    : 1.0  initial release
// ============================================================================
interface pc_trace_buffer_if;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_ins;

   modport master (
      output out_valid,
      output out_pc,
      output out_ins,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_pc,
      input  out_ins,
      output out_ready
   );
endinterface
`default_nettype wire

// File: rtl/pc_trace_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : pc_trace_buffer
//  Description : Observer for a single-cycle RISC-V core. Stores one
//                {PC, ins} entry per new instruction address in a FIFO,
//                drains it over a valid/ready bus, counts captures lost to a
//                full FIFO and flags a self-jump halt.
//  Ports       : clk           clock, rising edge
//                reset         synchronous active-high reset
//                PC, ins       core program counter / instruction
//                trace_en      capture enable
//                drain         head-entry valid/ready bus (master side)
//                count         current FIFO occupancy
//                overflow_cnt  dropped captures, saturating at 0xFFFF
//                halted        sticky halt flag
//  Revision    : 1.0  initial release
// ============================================================================
module pc_trace_buffer #(
   parameter int DEPTH       = 16,
   parameter int HALT_CYCLES = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [31:0]              PC,
   input  logic [31:0]              ins,
   input  logic                     trace_en,
   pc_trace_buffer_if.master        drain,
   output logic [$clog2(DEPTH):0]   count,
   output logic [15:0]              overflow_cnt,
   output logic                     halted
);

   localparam int AW  = $clog2(DEPTH);
   localparam int CW  = AW + 1;
   localparam int SCW = $clog2(HALT_CYCLES + 1);

   // Entry storage; not reset, the head outputs are masked while empty.
   logic [31:0]    pc_mem_q  [DEPTH];
   logic [31:0]    ins_mem_q [DEPTH];

   logic [AW-1:0]  wr_ptr_q,   wr_ptr_d;
   logic [AW-1:0]  rd_ptr_q,   rd_ptr_d;
   logic [CW-1:0]  count_q,    count_d;
   logic [15:0]    ovf_q,      ovf_d;
   logic           halted_q,   halted_d;
   logic           armed_q,    armed_d;
   logic [31:0]    last_pc_q,  last_pc_d;
   logic [31:0]    prev_pc_q;
   logic [SCW-1:0] same_cnt_q, same_cnt_d;

   logic w_full;
   logic w_empty;
   logic w_pop;
   logic w_cap;
   logic w_push;
   logic w_drop;
   logic w_same;

   // -------------------------------------------------------------------------
   // Capture / push / pop decisions
   // -------------------------------------------------------------------------
   always_comb begin
      w_full  = (count_q == CW'(DEPTH));
      w_empty = (count_q == '0);
      w_pop   = !w_empty && drain.out_ready;
      // A fresh enable (armed clear) always captures, even a repeated PC.
      w_cap   = trace_en && !halted_q && (!armed_q || (PC != last_pc_q));
      // A same-edge pop frees a slot in a full FIFO, so the push survives.
      w_push  = w_cap && (!w_full || w_pop);
      w_drop  = w_cap && w_full && !w_pop;
      w_same  = (PC == prev_pc_q);
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      ovf_d      = ovf_q;
      armed_d    = armed_q;
      last_pc_d  = last_pc_q;
      same_cnt_d = '0;
      halted_d   = halted_q;

      if (w_push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (w_pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end

      case ({w_push, w_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      if (w_drop && (ovf_q != 16'hFFFF)) begin
         ovf_d = ovf_q + 16'd1;
      end

      // last_pc follows every capture, including dropped ones, so a stalled
      // consumer does not cause the same PC to be retried.
      if (w_cap) begin
         last_pc_d = PC;
         armed_d   = 1'b1;
      end
      if (!trace_en) begin
         armed_d = 1'b0;
      end

      // Halt: HALT_CYCLES consecutive edges with PC equal to the previous PC.
      if (w_same) begin
         if (same_cnt_q == SCW'(HALT_CYCLES)) begin
            same_cnt_d = same_cnt_q;
         end else begin
            same_cnt_d = same_cnt_q + SCW'(1);
         end
      end
      if (w_same && (same_cnt_d == SCW'(HALT_CYCLES))) begin
         halted_d = 1'b1;
      end
   end

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         ovf_q      <= '0;
         halted_q   <= 1'b0;
         armed_q    <= 1'b0;
         last_pc_q  <= '0;
         prev_pc_q  <= '0;
         same_cnt_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         ovf_q      <= ovf_d;
         halted_q   <= halted_d;
         armed_q    <= armed_d;
         last_pc_q  <= last_pc_d;
         prev_pc_q  <= PC;
         same_cnt_q <= same_cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && w_push) begin
         pc_mem_q[wr_ptr_q]  <= PC;
         ins_mem_q[wr_ptr_q] <= ins;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs: show-ahead head, zeroed while empty
   // -------------------------------------------------------------------------
   always_comb begin
      drain.out_valid = !w_empty;
      drain.out_pc    = w_empty ? 32'h0 : pc_mem_q[rd_ptr_q];
      drain.out_ins   = w_empty ? 32'h0 : ins_mem_q[rd_ptr_q];
   end

   assign count        = count_q;
   assign overflow_cnt = ovf_q;
   assign halted       = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_trace_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_trace_buffer
//  Description : Self-checking bench for pc_trace_buffer. A queue-based
//                model tracks the FIFO contents, drop count and halt state;
//                a compare process checks every DUT output each cycle, and
//                directed scenarios add literal expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pc_trace_buffer;

   localparam int DEPTH = 16;
   localparam int H     = 8;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] ins;
   } ent_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] PC;
   logic [31:0] ins;
   logic        trace_en;
   logic [4:0]  count;
   logic [15:0] overflow_cnt;
   logic        halted;

   pc_trace_buffer_if dif ();

   pc_trace_buffer #(.DEPTH(DEPTH), .HALT_CYCLES(H)) dut (
      .clk          (clk),
      .reset        (reset),
      .PC           (PC),
      .ins          (ins),
      .trace_en     (trace_en),
      .drain        (dif),
      .count        (count),
      .overflow_cnt (overflow_cnt),
      .halted       (halted)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // model state
   ent_t        mq[$];
   logic [31:0] capq[$];
   logic [31:0] drnq[$];
   int          m_ovf    = 0;
   bit          m_halted = 0;
   bit          m_armed  = 0;
   logic [31:0] m_last   = 0;
   logic [31:0] m_prev   = 0;
   int          m_run    = 0;
   bit          m_live   = 0;
   logic [31:0] idle_pc  = 32'h0001_0000;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Apply the behavioural rules for one rising edge using the inputs as
   // the DUT sampled them.
   task automatic model_step();
      bit   pop, cap;
      ent_t e;
      m_live = 1;
      if (reset) begin
         mq.delete();
         m_ovf = 0; m_halted = 0; m_armed = 0; m_prev = 0; m_run = 0;
      end else begin
         pop = (mq.size() > 0) && dif.out_ready;
         cap = trace_en && !m_halted && (!m_armed || PC != m_last);
         if (pop) void'(mq.pop_front());
         if (cap) begin
            if (mq.size() < DEPTH) begin
               e.pc = PC; e.ins = ins;
               mq.push_back(e);
               capq.push_back(PC);
            end else if (m_ovf < 16'hFFFF) begin
               m_ovf++;
            end
            m_last  = PC;
            m_armed = 1;
         end
         if (!trace_en) m_armed = 0;
         if (PC == m_prev) m_run = (m_run < H) ? m_run + 1 : H;
         else              m_run = 0;
         if (m_run == H) m_halted = 1;
         m_prev = PC;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #2;
   endtask

   task automatic idle_step();
      trace_en = 1'b0;
      idle_pc  = idle_pc + 32'd4;
      PC       = idle_pc;
      ins      = $urandom;
      tick();
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (m_live) begin
         chk("out_valid", {31'b0, dif.out_valid}, {31'b0, mq.size() > 0});
         chk("out_pc",  dif.out_pc,  (mq.size() > 0) ? mq[0].pc  : 32'h0);
         chk("out_ins", dif.out_ins, (mq.size() > 0) ? mq[0].ins : 32'h0);
         chk("count", {27'b0, count}, mq.size());
         chk("count_le_depth", {31'b0, count <= 5'd16}, 32'd1);
         chk("overflow_cnt", {16'b0, overflow_cnt}, m_ovf);
         chk("halted", {31'b0, halted}, {31'b0, m_halted});
         if (dif.out_valid && dif.out_ready) drnq.push_back(dif.out_pc);
      end
   end

   initial begin
      bit drained;
      reset = 1'b1; PC = 0; ins = 0; trace_en = 1'b0; dif.out_ready = 1'b0;
      tick(); tick();
      reset = 1'b0;
      chk("rst_count", {27'b0, count}, 32'd0);
      chk("rst_valid", {31'b0, dif.out_valid}, 32'd0);
      chk("rst_ovf", {16'b0, overflow_cnt}, 32'd0);
      chk("rst_halted", {31'b0, halted}, 32'd0);

      // Four sequential PCs, then drain in order.
      trace_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         PC = 32'(i * 4); ins = 32'h0000_0013; tick();
      end
      chk("t1_count", {27'b0, count}, 32'd4);
      chk("t1_head", dif.out_pc, 32'h0);
      dif.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("t1_drain", dif.out_pc, 32'(i * 4));
         idle_step();
      end
      chk("t1_empty", {31'b0, dif.out_valid}, 32'd0);
      dif.out_ready = 1'b0;

      // Twenty PCs into a 16-deep FIFO.
      trace_en = 1'b1;
      for (int i = 0; i < 20; i++) begin
         PC = 32'(i * 4); ins = $urandom; tick();
      end
      chk("t2_count", {27'b0, count}, 32'd16);
      chk("t2_ovf", {16'b0, overflow_cnt}, 32'd4);
      chk("t2_head", dif.out_pc, 32'h0);
      chk("t2_model_tail", mq[mq.size()-1].pc, 32'h3C);

      // Full FIFO: same-edge pop makes room for 0x100.
      PC = 32'h100; ins = $urandom; dif.out_ready = 1'b1; tick();
      chk("t3_count", {27'b0, count}, 32'd16);
      chk("t3_ovf", {16'b0, overflow_cnt}, 32'd4);
      chk("t3_head", dif.out_pc, 32'h4);
      for (int i = 0; i < 16; i++) begin
         chk("t3_drain", dif.out_pc, (i == 15) ? 32'h100 : 32'((i + 1) * 4));
         idle_step();
      end
      chk("t3_empty", {31'b0, dif.out_valid}, 32'd0);
      dif.out_ready = 1'b0;

      // Self-jump halt.
      trace_en = 1'b1;
      PC = 32'h1C; ins = 32'h0000_0013; tick();
      PC = 32'h20; ins = 32'h0000_006F;
      for (int i = 0; i < H; i++) tick();
      chk("t4_not_yet_halted", {31'b0, halted}, 32'd0);
      tick();
      chk("t4_halted", {31'b0, halted}, 32'd1);
      chk("t4_count", {27'b0, count}, 32'd2);
      PC = 32'h24; tick();
      chk("t4_no_capture", {27'b0, count}, 32'd2);

      // Reset clears halt, then a mid-operation reset discards entries.
      reset = 1'b1; tick(); reset = 1'b0;
      chk("t5_halt_cleared", {31'b0, halted}, 32'd0);
      trace_en = 1'b1;
      for (int i = 4; i >= 0; i--) begin
         PC = 32'(i * 4); ins = $urandom; tick();
      end
      chk("t5_count5", {27'b0, count}, 32'd5);
      reset = 1'b1; PC = 32'h0; tick(); reset = 1'b0;
      chk("t5_count", {27'b0, count}, 32'd0);
      chk("t5_valid", {31'b0, dif.out_valid}, 32'd0);
      chk("t5_ovf", {16'b0, overflow_cnt}, 32'd0);
      chk("t5_halted", {31'b0, halted}, 32'd0);
      tick();
      chk("t5_recapture", {27'b0, count}, 32'd1);
      chk("t5_recapture_pc", dif.out_pc, 32'h0);
      dif.out_ready = 1'b1;
      idle_step();

      // Random consumer back-pressure over 100 increasing PCs.
      capq.delete(); drnq.delete();
      trace_en = 1'b1;
      for (int i = 0; i < 100; i++) begin
         PC = 32'h4000 + 32'(i * 4);
         ins = $urandom;
         dif.out_ready = ($urandom_range(0, 7) != 0);
         tick();
      end
      dif.out_ready = 1'b1;
      drained = 0;
      for (int i = 0; i < 40 && !drained; i++) begin
         if (!dif.out_valid) drained = 1;
         else idle_step();
      end
      chk("t6_drain_done", {31'b0, drained}, 32'd1);
      chk("t6_len", drnq.size(), capq.size());
      for (int i = 0; i < drnq.size() && i < capq.size(); i++)
         chk("t6_order", drnq[i], capq[i]);
      if (overflow_cnt == 16'd0) begin
         chk("t6_no_gap_len", drnq.size(), 32'd100);
         for (int i = 0; i < drnq.size(); i++)
            chk("t6_no_gap", drnq[i], 32'h4000 + 32'(i * 4));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pc_trace_buffer.md
# pc_trace_buffer

Downstream observer of the single-cycle `riscv` core. It samples the core's `PC`/`ins` outputs every cycle and stores one entry per new instruction address in a FIFO. A valid/ready port drains the stored pairs to a debug or UART consumer. It also detects a self-jump halt and counts entries lost to a full FIFO.

## Interface
- `DEPTH`, 16, FIFO entries; power of two, ≥2.
- `HALT_CYCLES`, 8, consecutive repeats of an unchanged `PC` that declare a halt; ≥1.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `PC`  in  32  core program counter.
- `ins`  in  32  instruction at `PC`.
- `trace_en`  in  1  capture enable.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  consumer accepts head.
- `out_pc`  out  32  head PC.
- `out_ins`  out  32  head instruction.
- `count`  out  log2(DEPTH)+1  current occupancy.
- `overflow_cnt`  out  16  dropped captures, saturating.
- `halted`  out  1  sticky halt flag.

## Operation
- **Reset.** On a rising edge with `reset`=1:
  - `count`, `overflow_cnt`, `halted`, read/write pointers, `same_cnt` and `armed` are cleared to 0.
  - `out_valid`=0; `out_pc`=`out_ins`=0.
  - `prev_pc` loads 0.
  - Reset in the middle of operation discards all stored entries.
- **Capture condition (per edge).** `cap = trace_en && !halted && (!armed || PC != last_pc)`.
  - On capture: `last_pc` <= `PC` and `armed` <= 1.
  - While `trace_en`=0, `armed` is cleared. The first sample after re-enable is therefore always captured.
- **Push.** A capture pushes {`PC`, `ins`}.
  - If the FIFO is full and no pop occurs on the same edge, the entry is dropped.
  - `overflow_cnt` increments on a drop and saturates at 0xFFFF.
  - `last_pc` still updates on a drop.
- **Pop.** `pop = out_valid && out_ready`; it advances the read pointer.
- **Simultaneous push and pop.**
  - Both take effect and `count` is unchanged.
  - When full, a same-edge pop makes room: the push is accepted and there is no overflow.
  - When empty, there is no bypass; only the push takes effect.
- **Pointers.** log2(DEPTH) bits, wrapping modulo DEPTH. Full is `count==DEPTH`.
- **Head outputs.**
  - `out_valid = (count != 0)`.
  - `out_pc`/`out_ins` show the head entry combinationally from storage (show-ahead).
  - Both are forced to 0 when `out_valid`=0.
- **Halt detection.** Runs every edge, independent of `trace_en`.
  - `prev_pc` <= `PC` each edge.
  - If `PC == prev_pc`, `same_cnt` increments, saturating at `HALT_CYCLES`; otherwise it is cleared to 0.
  - `halted` is set on the edge where `same_cnt` would reach `HALT_CYCLES`. It stays 1 until reset.
  - Once halted, capture stops; draining continues normally.

## Timing
- Capture latency: a `PC` sampled at edge k shows `out_valid`=1 and the head data after edge k when the FIFO was empty.
- Pop: the head is consumed at the edge where `out_valid && out_ready`. The next entry appears after that edge.
- Sustained throughput: one push and one pop per cycle.
- `count` and `overflow_cnt` are registered and change only on clock edges.
- `halted` rises after the `HALT_CYCLES`-th consecutive edge with an unchanged `PC`. At `HALT_CYCLES`=8, a `PC` held from edge j onward (`prev_pc` equal from edge j+1) sets `halted` after edge j+8.
- `ins` changes with no change in `PC` do not create entries.

## Test plan
- Reset, then `trace_en`=1, `out_ready`=0, `PC`=0x0,0x4,0x8,0xC with `ins`=0x00000013 each -> `count`=4, `out_pc`=0x0. Draining with `out_ready`=1 gives 0x0,0x4,0x8,0xC in order, then `out_valid`=0.
- `DEPTH`=16, `out_ready`=0, 20 distinct PCs 0x0..0x4C -> `count`=16, `overflow_cnt`=4, head `out_pc`=0x0, tail entry 0x3C.
- Full FIFO, new `PC`=0x100 with `out_ready`=1 on the same edge -> `count` stays 16, `overflow_cnt` unchanged, head becomes 0x4, and 0x100 is stored last.
- `PC` advances to 0x20 and then holds at 0x20 (`ins`=0x0000006F) -> exactly one entry for 0x20; `halted`=1 after 8 repeat edges. A following `PC`=0x24 is not captured.
- `count`=5, one-cycle `reset` pulse -> `count`=0, `out_valid`=0, `overflow_cnt`=0, `halted`=0. Next `PC`=0x0 is captured even though it equals the pre-reset `last_pc`.
- Random `out_ready` toggling over 100 increasing PCs with `DEPTH`=16 -> drained sequence equals the captured sequence with no gaps while `overflow_cnt`=0, and `count` is never above 16.
